zl_usb_cmd_dispatch: RTL and testbench
======================================

# zl_usb_cmd_dispatch

Packet dispatcher that sits directly downstream of the USB receive FIFO interface and consumes its req/ack byte stream. It frames the stream into packets, delivers stream payload to one of three downstream byte consumers, and decodes register-write packets into a single-cycle register write strobe. It owns upstream flow control and recovers from corrupt framing by hunting for a sync byte.

## Interface
- SYNC_BYTE, 8'hA5, packet start marker
- TIMEOUT_CYCLES, 16'd50000, inter-byte idle limit mid-packet (only with timeout feature)
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_req  in  1  upstream byte valid; held until acked
- in_ack  out  1  upstream byte consumed this cycle; combinational from in_req and state
- in_data  in  8  upstream byte, valid while in_req
- out_req  out  3  per-channel byte valid, one-hot or zero, registered
- out_ack  in  3  per-channel consume; only the bit matching an asserted out_req is honoured
- out_data  out  8  byte for the channel in out_req
- reg_wr  out  1  one-cycle register write strobe
- reg_addr  out  8  write address, held until next write
- reg_wdata  out  8  write data, held until next write
- pkt_done  out  1  one-cycle pulse per completed or discarded packet
- busy  out  1  high in any state other than S_hunt, or while out_req nonzero
- err_cnt  out  8  saturating error count (holds at 255)

## Operation
- Packet: SYNC_BYTE, header, length N (0..255), N payload bytes. Header[1:0] = dest: 0..2 stream channel, 3 register write. Header[7:2] ignored.
- All upstream bytes are accepted as in_req && in_ack; in_ack is never high without in_req.
- States: S_hunt, S_header, S_length, S_payload, S_reg_addr, S_reg_data, S_drain.
- S_hunt: in_ack = in_req. Byte == SYNC_BYTE -> S_header; any other byte is discarded, err_cnt++.
- S_header: accept, latch dest -> S_length.
- S_length: accept, latch N. N==0 -> S_hunt + pkt_done. dest 0..2 -> S_payload. dest 3 and N==2 -> S_reg_addr. dest 3 and N!=2 -> S_drain, err_cnt++.
- S_payload: one-byte hold register {valid, ch, byte}. in_ack = in_req && (!hold_valid || out_ack[hold_ch]). Accepted byte loads hold with the current dest, count decrements. Last byte -> S_hunt + pkt_done. Hold drains independently of state, so the next packet's header may be parsed while the hold is still pending.
- out_req[hold_ch] = hold_valid; hold clears on out_ack[hold_ch] unless reloaded the same cycle.
- S_reg_addr: accept, latch address -> S_reg_data. S_reg_data: accept; next cycle reg_wr=1 with reg_addr/reg_wdata updated, pkt_done=1 -> S_hunt.
- S_drain: in_ack = in_req, discard N bytes, last -> S_hunt + pkt_done.
- Simultaneous error sources in one cycle: err_cnt increments by 1.

## Timing
- Reset: state S_hunt, in_ack 0 (in_req is don't-care), out_req 0, out_data 0, reg_wr 0, reg_addr 0, reg_wdata 0, pkt_done 0, busy 0, err_cnt 0, hold invalid. Reset mid-packet discards the hold byte and any partial packet.
- in_ack is combinational; all other outputs are registered.
- Payload latency: byte accepted in cycle t -> out_req/out_data valid in t+1.
- Sustained throughput of 1 byte/cycle is possible when downstream acks in the same cycle out_req is seen.
- pkt_done and reg_wr are asserted in the cycle after the final byte is accepted.
- Downstream stall: in_ack stays low indefinitely; no byte loss, no error.

## Configuration
- ZL_USB_CMD_DISPATCH_TIMEOUT_EN defined: a 16-bit idle counter runs in every state except S_hunt. It increments on cycles with in_req low and clears on every accepted byte and on entry to S_hunt. When it reaches TIMEOUT_CYCLES: go to S_hunt, err_cnt++, no pkt_done, and the hold register is left to drain.
- Not defined: no counter; a partial packet waits forever and TIMEOUT_CYCLES is unused.

## Test plan
- A5,01,03,11,22,33 with out_ack[1] tied high -> out_req=3'b010 carries 11,22,33 on consecutive cycles; one pkt_done; err_cnt 0.
- A5,03,02,40,5A -> one reg_wr pulse with reg_addr=40, reg_wdata=5A; out_req stays 0; one pkt_done.
- 00,FF,A5,00,00 -> err_cnt=2; zero-length packet gives pkt_done, no out_req.
- A5,03,01,77 -> drained, err_cnt=1, no reg_wr, one pkt_done; a following A5,02,01,99 delivers 99 on channel 2.
- A5,00,02,AA,BB with out_ack[0] low for 20 cycles -> AA is held on out_req[0], in_ack stays low on BB; after the ack, BB is delivered; no error.
- With ZL_USB_CMD_DISPATCH_TIMEOUT_EN and TIMEOUT_CYCLES=10: A5,00,04,01 then idle -> returns to S_hunt after 10 idle cycles, err_cnt=1, byte 01 still delivered. Reset asserted mid-packet -> all outputs return to their reset values.

Source files
------------

// File: rtl/zl_usb_cmd_dispatch.sv
// ---------------------------------------------------------------------------
// zl_usb_cmd_dispatch
//
// Frames the USB receive FIFO byte stream (req/ack) into packets of the form
//   SYNC_BYTE, header, length N, N payload bytes
// header[1:0] selects the destination: 0..2 stream channel, 3 register write.
// Stream payload is handed to the selected channel through a one-byte hold
// register; register-write packets (N==2: addr, data) produce a one-cycle
// reg_wr strobe. Any byte that is not a sync byte while hunting is dropped
// and counted as an error.
//
// Optional feature (macro ZL_USB_CMD_DISPATCH_TIMEOUT_EN): mid-packet idle
// timeout of TIMEOUT_CYCLES cycles with in_req low; on expiry the partial
// packet is abandoned (no pkt_done) and err_cnt increments. Without the
// macro a partial packet waits indefinitely.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_req/in_ack   upstream handshake; in_ack is combinational
//   in_data         upstream byte
//   out_req         per-channel byte valid (one-hot or zero)
//   out_ack         per-channel consume
//   out_data        byte for the channel flagged in out_req
//   reg_wr          one-cycle register write strobe
//   reg_addr        write address, held until the next write
//   reg_wdata       write data, held until the next write
//   pkt_done        one-cycle pulse per completed or discarded packet
//   busy            parser not hunting, or a byte still held for output
//   err_cnt         saturating error counter
// ---------------------------------------------------------------------------
module zl_usb_cmd_dispatch #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_req,
   output logic       in_ack,
   input  logic [7:0] in_data,
   output logic [2:0] out_req,
   input  logic [2:0] out_ack,
   output logic [7:0] out_data,
   output logic       reg_wr,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       pkt_done,
   output logic       busy,
   output logic [7:0] err_cnt
);

   localparam int         NUM_CH   = 3;
   localparam logic [1:0] DEST_REG = 2'd3;

   typedef enum logic [2:0] {
      S_hunt,
      S_header,
      S_length,
      S_payload,
      S_reg_addr,
      S_reg_data,
      S_drain
   } state_t;

   typedef struct packed {
      logic       vld;
      logic [1:0] ch;
      logic [7:0] dat;
   } hold_t;

   state_t     state;
   hold_t      hold;
   logic [1:0] dest;
   logic [7:0] cnt;
   logic [7:0] addr_q;

   logic [3:0] ack_pad;
   logic       hold_rel;
   logic       acc;
   logic       err_ev;
   logic       tmo;

   // Pad to four bits so a 2-bit channel index can never select past the end.
   assign ack_pad  = {1'b0, out_ack};
   assign hold_rel = hold.vld && ack_pad[hold.ch];

   // Only payload bytes can be back-pressured by the hold register; every
   // other state consumes immediately. Forced low while reset is asserted.
   always_comb begin
      in_ack = 1'b0;
      if (rst_n) begin
         if (state == S_payload) in_ack = in_req && (!hold.vld || hold_rel);
         else                    in_ack = in_req;
      end
   end

   assign acc = in_ack;

`ifdef ZL_USB_CMD_DISPATCH_TIMEOUT_EN
   logic [15:0] idle_cnt;

   // Fires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
   assign tmo = (state != S_hunt) && !in_req &&
                ((idle_cnt + 16'd1) == TIMEOUT_CYCLES);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                               idle_cnt <= '0;
      else if (state == S_hunt || acc || tmo)   idle_cnt <= '0;
      else if (!in_req)                         idle_cnt <= idle_cnt + 16'd1;
   end
`else
   logic unused_timeout;
   assign tmo            = 1'b0;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Error sources are mutually exclusive in practice, but they are OR-ed so
   // the counter can never step by more than one per cycle.
   always_comb begin
      err_ev = tmo;
      if (acc && state == S_hunt && in_data != SYNC_BYTE) err_ev = 1'b1;
      if (acc && state == S_length && in_data != 8'd0 &&
          dest == DEST_REG && in_data != 8'd2)            err_ev = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_hunt;
         hold      <= '0;
         dest      <= '0;
         cnt       <= '0;
         addr_q    <= '0;
         reg_wr    <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         pkt_done  <= 1'b0;
         err_cnt   <= '0;
      end else begin
         pkt_done <= 1'b0;
         reg_wr   <= 1'b0;

         if (err_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

         // Hold register drains on its own, independent of the parser state,
         // so the next header can be parsed while a byte is still pending.
         if (acc && state == S_payload)
            hold <= '{vld: 1'b1, ch: dest, dat: in_data};
         else if (hold_rel)
            hold.vld <= 1'b0;

         if (tmo) begin
            state <= S_hunt;
         end else if (acc) begin
            case (state)
               S_hunt: begin
                  if (in_data == SYNC_BYTE) state <= S_header;
               end
               S_header: begin
                  dest  <= in_data[1:0];
                  state <= S_length;
               end
               S_length: begin
                  cnt <= in_data;
                  if (in_data == 8'd0) begin
                     state    <= S_hunt;
                     pkt_done <= 1'b1;
                  end else if (dest != DEST_REG) begin
                     state <= S_payload;
                  end else if (in_data == 8'd2) begin
                     state <= S_reg_addr;
                  end else begin
                     state <= S_drain;
                  end
               end
               S_payload, S_drain: begin
                  cnt <= cnt - 8'd1;
                  if (cnt == 8'd1) begin
                     state    <= S_hunt;
                     pkt_done <= 1'b1;
                  end
               end
               S_reg_addr: begin
                  addr_q <= in_data;
                  state  <= S_reg_data;
               end
               S_reg_data: begin
                  reg_addr  <= addr_q;
                  reg_wdata <= in_data;
                  reg_wr    <= 1'b1;
                  pkt_done  <= 1'b1;
                  state     <= S_hunt;
               end
               default: state <= S_hunt;
            endcase
         end
      end
   end

   // Per-channel valid decode straight from the hold register.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign out_req[c] = hold.vld && (hold.ch == 2'(c));
   end

   assign out_data = hold.dat;
   assign busy     = (state != S_hunt) || hold.vld;

endmodule

// File: tb/tb_zl_usb_cmd_dispatch.sv
module tb_zl_usb_cmd_dispatch;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_req = 1'b0;
   logic       in_ack;
   logic [7:0] in_data = 8'h00;
   logic [2:0] out_req;
   logic [2:0] out_ack = 3'b000;
   logic [7:0] out_data;
   logic       reg_wr;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       pkt_done;
   logic       busy;
   logic [7:0] err_cnt;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int e_err = 0;

   // monitor state
   int         n_done = 0;
   int         n_wr = 0;
   int         n_bad1h = 0;
   logic [2:0] q_ch[$];
   logic [7:0] q_dat[$];
   int         q_cyc[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

`ifdef ZL_USB_CMD_DISPATCH_TIMEOUT_EN
   zl_usb_cmd_dispatch #(.TIMEOUT_CYCLES(16'd10)) dut (
`else
   zl_usb_cmd_dispatch dut (
`endif
      .clk(clk), .rst_n(rst_n),
      .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
      .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
      .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .pkt_done(pkt_done), .busy(busy), .err_cnt(err_cnt)
   );

   // Passive monitor, sampled 2 time units after the falling edge.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (pkt_done) n_done++;
         if (reg_wr)   n_wr++;
         if (out_req != 3'b000 && !$onehot(out_req)) n_bad1h++;
         if ((out_req & out_ack) != 3'b000) begin
            q_ch.push_back(out_req);
            q_dat.push_back(out_data);
            q_cyc.push_back(cyc);
         end
      end
   end

   task automatic clr();
      @(negedge clk);
      n_done = 0;
      n_wr   = 0;
      q_ch.delete();
      q_dat.delete();
      q_cyc.delete();
   endtask

   task automatic settle();
      repeat (4) @(negedge clk);
      #3;
   endtask

   // Present one byte from a falling edge; return on the falling edge after it
   // was accepted, with in_req dropped (a following send re-raises it at once).
   task automatic send(input logic [7:0] b);
      int n = 0;
      in_req  = 1'b1;
      in_data = b;
      #1;
      while (!in_ack && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!in_ack) begin
         n_vec++; n_err++;
         $display("FAIL send_ack: byte %02h never acked after %0d cycles", b, n);
      end
      @(negedge clk);
      in_req = 1'b0;
   endtask

   task automatic send_n(input logic [63:0] bytes, input int n);
      for (int i = 0; i < n; i++) send(bytes[8*(n-1-i) +: 8]);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      in_req  = 1'b1;
      in_data = 8'hA5;
      out_ack = 3'b111;
      #3;
      n_vec++;
      if ({in_ack, out_req, out_data, reg_wr, reg_addr, reg_wdata, pkt_done, busy, err_cnt} !== 46'd0) begin
         n_err++;
         $display("FAIL reset_outputs: ack=%b req=%b data=%h wr=%b addr=%h wd=%h done=%b busy=%b err=%0d want all zero",
                  in_ack, out_req, out_data, reg_wr, reg_addr, reg_wdata, pkt_done, busy, err_cnt);
      end
      repeat (3) @(negedge clk);
      n_vec++;
      if ({in_ack, busy, err_cnt} !== 10'd0) begin
         n_err++;
         $display("FAIL reset_held: ack=%b busy=%b err=%0d want 0 0 0", in_ack, busy, err_cnt);
      end
      in_req  = 1'b0;
      out_ack = 3'b000;
      rst_n   = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({in_ack, out_req, busy, pkt_done} !== 6'd0) begin
         n_err++;
         $display("FAIL reset_release: ack=%b req=%b busy=%b done=%b want zero", in_ack, out_req, busy, pkt_done);
      end
   endtask

   task automatic test_stream();
      clr();
      out_ack = 3'b010;
      send_n({8'hA5, 8'h01, 8'h03, 8'h11, 8'h22, 8'h33}, 6);
      settle();
      n_vec++;
      if (q_dat.size() != 3) begin
         n_err++; $display("FAIL stream_count: got %0d want 3", q_dat.size());
      end
      n_vec++;
      if ({q_ch[0], q_ch[1], q_ch[2]} !== 9'b010_010_010) begin
         n_err++; $display("FAIL stream_chan: got %b %b %b want 010", q_ch[0], q_ch[1], q_ch[2]);
      end
      n_vec++;
      if ({q_dat[0], q_dat[1], q_dat[2]} !== 24'h112233) begin
         n_err++; $display("FAIL stream_data: got %h %h %h want 11 22 33", q_dat[0], q_dat[1], q_dat[2]);
      end
      n_vec++;
      if (q_cyc[1] != q_cyc[0] + 1 || q_cyc[2] != q_cyc[1] + 1) begin
         n_err++; $display("FAIL stream_rate: cycles %0d %0d %0d want consecutive", q_cyc[0], q_cyc[1], q_cyc[2]);
      end
      n_vec++;
      if (n_done != 1 || err_cnt !== 8'(e_err)) begin
         n_err++; $display("FAIL stream_done_err: done=%0d err=%0d want 1 %0d", n_done, err_cnt, e_err);
      end
   endtask

   task automatic test_reg_write();
      clr();
      out_ack = 3'b111;
      send_n({8'hA5, 8'h03, 8'h02, 8'h40, 8'h5A}, 5);
      #1;
      n_vec++;
      if ({reg_wr, pkt_done, reg_addr, reg_wdata} !== {2'b11, 8'h40, 8'h5A}) begin
         n_err++; $display("FAIL regwr_pulse: wr=%b done=%b addr=%h data=%h want 1 1 40 5a",
                           reg_wr, pkt_done, reg_addr, reg_wdata);
      end
      settle();
      n_vec++;
      if (n_wr != 1 || n_done != 1 || q_dat.size() != 0) begin
         n_err++; $display("FAIL regwr_counts: wr=%0d done=%0d bytes=%0d want 1 1 0", n_wr, n_done, q_dat.size());
      end
      n_vec++;
      if ({reg_addr, reg_wdata, err_cnt} !== {8'h40, 8'h5A, 8'(e_err)}) begin
         n_err++; $display("FAIL regwr_hold: addr=%h data=%h err=%0d want 40 5a %0d", reg_addr, reg_wdata, err_cnt, e_err);
      end
   endtask

   task automatic test_hunt();
      clr();
      out_ack = 3'b111;
      send_n({8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00}, 5);
      settle();
      e_err += 2;
      n_vec++;
      if (err_cnt !== 8'(e_err)) begin
         n_err++; $display("FAIL hunt_err: got %0d want %0d", err_cnt, e_err);
      end
      n_vec++;
      if (n_done != 1 || q_dat.size() != 0 || busy !== 1'b0) begin
         n_err++; $display("FAIL hunt_zero_len: done=%0d bytes=%0d busy=%b want 1 0 0", n_done, q_dat.size(), busy);
      end
   endtask

   task automatic test_drain();
      clr();
      out_ack = 3'b100;
      send_n({8'hA5, 8'h03, 8'h01, 8'h77}, 4);
      settle();
      e_err += 1;
      n_vec++;
      if (err_cnt !== 8'(e_err) || n_wr != 0 || n_done != 1 || q_dat.size() != 0) begin
         n_err++; $display("FAIL drain: err=%0d wr=%0d done=%0d bytes=%0d want %0d 0 1 0",
                           err_cnt, n_wr, n_done, q_dat.size(), e_err);
      end
      clr();
      send_n({8'hA5, 8'h02, 8'h01, 8'h99}, 4);
      settle();
      n_vec++;
      if (q_dat.size() != 1 || q_ch[0] !== 3'b100 || q_dat[0] !== 8'h99 || n_done != 1) begin
         n_err++; $display("FAIL drain_next: bytes=%0d ch=%b data=%h done=%0d want 1 100 99 1",
                           q_dat.size(), q_ch[0], q_dat[0], n_done);
      end
   endtask

   task automatic test_stall();
      clr();
      out_ack = 3'b000;
      send_n({8'hA5, 8'h00, 8'h02, 8'hAA}, 4);
      fork
         send(8'hBB);
         begin
            repeat (20) @(negedge clk);
            n_vec++;
            if ({out_req, out_data, in_ack, busy} !== {3'b001, 8'hAA, 1'b0, 1'b1}) begin
               n_err++; $display("FAIL stall_hold: req=%b data=%h ack=%b busy=%b want 001 aa 0 1",
                                 out_req, out_data, in_ack, busy);
            end
            out_ack = 3'b001;
         end
      join
      settle();
      n_vec++;
      if (q_dat.size() != 2 || {q_dat[0], q_dat[1]} !== 16'hAABB || {q_ch[0], q_ch[1]} !== 6'b001_001) begin
         n_err++; $display("FAIL stall_deliver: n=%0d data=%h %h ch=%b %b want 2 aa bb 001",
                           q_dat.size(), q_dat[0], q_dat[1], q_ch[0], q_ch[1]);
      end
      n_vec++;
      if (err_cnt !== 8'(e_err) || n_done != 1) begin
         n_err++; $display("FAIL stall_err: err=%0d done=%0d want %0d 1", err_cnt, n_done, e_err);
      end
   endtask

   task automatic test_back_to_back();
      clr();
      out_ack = 3'b000;
      send_n({8'hA5, 8'h00, 8'h01, 8'hC1}, 4);
      #1;
      n_vec++;
      if ({pkt_done, busy, out_req} !== {1'b1, 1'b1, 3'b001}) begin
         n_err++; $display("FAIL b2b_pending: done=%b busy=%b req=%b want 1 1 001", pkt_done, busy, out_req);
      end
      send_n({8'hA5, 8'h01, 8'h01}, 3);
      fork
         send(8'hD2);
         begin
            repeat (3) @(negedge clk);
            out_ack = 3'b011;
         end
      join
      settle();
      n_vec++;
      if (q_dat.size() != 2 || {q_dat[0], q_dat[1]} !== 16'hC1D2 || {q_ch[0], q_ch[1]} !== 6'b001_010) begin
         n_err++; $display("FAIL b2b_deliver: n=%0d data=%h %h ch=%b %b want 2 c1 d2 001 010",
                           q_dat.size(), q_dat[0], q_dat[1], q_ch[0], q_ch[1]);
      end
      n_vec++;
      if (n_done != 2 || err_cnt !== 8'(e_err)) begin
         n_err++; $display("FAIL b2b_done: done=%0d err=%0d want 2 %0d", n_done, err_cnt, e_err);
      end
   endtask

`ifdef ZL_USB_CMD_DISPATCH_TIMEOUT_EN
   task automatic test_timeout();
      clr();
      out_ack = 3'b001;
      send_n({8'hA5, 8'h00, 8'h04, 8'h01}, 4);
      repeat (9) @(negedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL timeout_early: busy=%b want 1 after 9 idle cycles", busy);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL timeout_fire: busy=%b want 0 after 10 idle cycles", busy);
      end
      settle();
      e_err += 1;
      n_vec++;
      if (err_cnt !== 8'(e_err) || n_done != 0 || q_dat.size() != 1 || q_dat[0] !== 8'h01) begin
         n_err++; $display("FAIL timeout_result: err=%0d done=%0d n=%0d data=%h want %0d 0 1 01",
                           err_cnt, n_done, q_dat.size(), q_dat[0], e_err);
      end
   endtask
`endif

   task automatic test_reset_mid();
      clr();
      out_ack = 3'b000;
      send_n({8'hA5, 8'h00, 8'h03, 8'h01}, 4);
      #1;
      n_vec++;
      if ({out_req, out_data, busy} !== {3'b001, 8'h01, 1'b1}) begin
         n_err++; $display("FAIL midrst_pre: req=%b data=%h busy=%b want 001 01 1", out_req, out_data, busy);
      end
      in_req  = 1'b1;
      in_data = 8'h55;
      #1;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({in_ack, out_req, out_data, reg_wr, reg_addr, reg_wdata, pkt_done, busy, err_cnt} !== 46'd0) begin
         n_err++;
         $display("FAIL midrst_outputs: ack=%b req=%b data=%h wr=%b addr=%h wd=%h done=%b busy=%b err=%0d want all zero",
                  in_ack, out_req, out_data, reg_wr, reg_addr, reg_wdata, pkt_done, busy, err_cnt);
      end
      @(negedge clk);
      in_req = 1'b0;
      rst_n  = 1'b1;
      e_err  = 0;
      out_ack = 3'b010;
      clr();
      send_n({8'hA5, 8'h01, 8'h01, 8'h5C}, 4);
      settle();
      n_vec++;
      if (q_dat.size() != 1 || q_ch[0] !== 3'b010 || q_dat[0] !== 8'h5C || n_done != 1 || err_cnt !== 8'd0) begin
         n_err++; $display("FAIL midrst_recover: n=%0d ch=%b data=%h done=%0d err=%0d want 1 010 5c 1 0",
                           q_dat.size(), q_ch[0], q_dat[0], n_done, err_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_reg_write();
      test_hunt();
      test_drain();
      test_stall();
      test_back_to_back();
`ifdef ZL_USB_CMD_DISPATCH_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      n_vec++;
      if (n_bad1h != 0) begin
         n_err++; $display("FAIL onehot: %0d cycles with multi-hot out_req, want 0", n_bad1h);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
